seq_alu_unit: RTL

- Parametrised successor to the datapath's single-cycle ALU.
- Registered ALU with a valid/ready input handshake.
- Extends the op set with XOR, SRL, SRA, SLTU and signed SLT.
- Adds iterative unsigned multiply (MULTU) and divide (DIVU) that produce a HI/LO pair; sits in the EX stage, which stalls on in_ready low.

---
 rtl/seq_alu_unit.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/seq_alu_unit.sv
// Registered ALU with a valid/ready input handshake. Single-cycle ops complete
// in the accept cycle; MULTU (shift-add) and DIVU (restoring) iterate one bit
// per clock and return a HI/LO pair after WIDTH cycles.
module seq_alu_unit #(
    parameter int  WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic [3:0]       control_lines,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero_flag,
    output logic             div_by_zero
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLTU = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MULT = 4'b1101;
    localparam logic [3:0] OP_DIVU = 4'b1110;

    localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;        // multiplicand or divisor
    logic [WIDTH-1:0] work_hi_q, work_hi_d;  // product upper half or remainder
    logic [WIDTH-1:0] work_lo_q, work_lo_d;  // multiplier bits or quotient/dividend
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             zero_q, zero_d;
    logic             dbz_q, dbz_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_fits;
    logic [WIDTH-1:0] alu_res;

    // Combinational single-cycle operation; shifts take the amount from operand A.
    function automatic logic [WIDTH-1:0] alu_eval(input logic [3:0]       op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic signed [WIDTH-1:0] sra_v;
        logic [SHW-1:0]          sh;
        logic [WIDTH-1:0]        r;
        sa    = a;
        sb    = b;
        sh    = a[SHW-1:0];
        sra_v = sb >>> sh;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, (sa < sb)};
            OP_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  r = b << sh;
            OP_SRL:  r = b >> sh;
            OP_SRA:  r = sra_v;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign alu_res = alu_eval(control_lines, input1, input2);

    // One shift-add step: add multiplicand to the upper half when the current
    // multiplier LSB is set, then shift the whole 2*WIDTH pair right by one.
    assign mul_sum = {1'b0, work_hi_q} + {1'b0, (work_lo_q[0] ? op_a_q : '0)};

    // One restoring step: bring the next dividend bit into the partial remainder.
    assign div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
    assign div_fits  = (div_shift >= {1'b0, op_a_q});

    // Next-state and datapath update for the IDLE/MUL/DIV sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_a_d      = op_a_q;
        work_hi_d   = work_hi_q;
        work_lo_d   = work_lo_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        dbz_d       = dbz_q;
        out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (control_lines == OP_MULT) begin
                        state_d   = MUL;
                        cnt_d     = '0;
                        op_a_d    = input1;
                        work_hi_d = '0;
                        work_lo_d = input2;
                    end else if (control_lines == OP_DIVU) begin
                        state_d   = DIV;
                        cnt_d     = '0;
                        op_a_d    = input2;
                        work_hi_d = '0;
                        work_lo_d = input1;
                    end else begin
                        result_d    = alu_res;
                        result_hi_d = '0;
                        zero_d      = (alu_res == '0);
                        dbz_d       = 1'b0;
                        out_valid_d = 1'b1;
                    end
                end
            end
            MUL: begin
                work_hi_d = mul_sum[WIDTH:1];
                work_lo_d = {mul_sum[0], work_lo_q[WIDTH-1:1]};
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    result_d    = {mul_sum[0], work_lo_q[WIDTH-1:1]};
                    result_hi_d = mul_sum[WIDTH:1];
                    zero_d      = ({mul_sum[0], work_lo_q[WIDTH-1:1]} == '0);
                    dbz_d       = 1'b0;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end
            end
            DIV: begin
                if (div_fits) begin
                    work_hi_d = WIDTH'(div_shift - {1'b0, op_a_q});
                    work_lo_d = {work_lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    work_hi_d = div_shift[WIDTH-1:0];
                    work_lo_d = {work_lo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    result_d    = work_lo_d;
                    result_hi_d = work_hi_d;
                    zero_d      = (work_lo_d == '0);
                    dbz_d       = (op_a_q == '0);
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Iteration registers and registered outputs; reset discards any in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            op_a_q      <= '0;
            work_hi_q   <= '0;
            work_lo_q   <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            op_a_q      <= op_a_d;
            work_hi_q   <= work_hi_d;
            work_lo_q   <= work_lo_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            dbz_q       <= dbz_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign result_hi   = result_hi_q;
    assign zero_flag   = zero_q;
    assign div_by_zero = dbz_q;

endmodule
